// File: rtl/pathtracer_pixel_assembler_if.sv
// Pixel assembler bus: serial colour byte stream in, tagged 24-bit pixel out.
// master = the assembler; slave = the surrounding source/sink logic.
interface pathtracer_pixel_assembler_if #(
  parameter int XW = 6,
  parameter int YW = 6
);
  logic [7:0]    pxl_serial_dat;
  logic          pxl_serial_vld;
  logic          pxl_serial_rdy;
  logic [23:0]   pix_rgb;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;
  logic          pix_vld;
  logic          pix_rdy;
  logic          frame_done;
  logic [15:0]   frame_cksum;

  modport master (
    input  pxl_serial_dat, pxl_serial_vld, pix_rdy,
    output pxl_serial_rdy, pix_rgb, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
           pix_vld, frame_done, frame_cksum
  );

  modport slave (
    output pxl_serial_dat, pxl_serial_vld, pix_rdy,
    input  pxl_serial_rdy, pix_rgb, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
           pix_vld, frame_done, frame_cksum
  );
endinterface

// File: rtl/pathtracer_pixel_assembler.sv
// Pathtracer pixel assembler: gathers R,G,B serial bytes into 24-bit pixels,
// tags each with raster x/y and sof/eol/eof, and presents it on a 1-deep
// registered vld/rdy output.
// Optional: define PIXEL_ASSEMBLER_CHECKSUM_EN to build the per-frame byte
// checksum on frame_cksum; otherwise frame_cksum is constant zero.
module pathtracer_pixel_assembler #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int XW         = 6,
  parameter int YW         = 6
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  pathtracer_pixel_assembler_if.master bus
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;

  phase_t        r_phase, w_phase_nxt;
  logic [7:0]    r_q, r_g_q;
  logic [XW-1:0] r_x_cnt;
  logic [YW-1:0] r_y_cnt;
  logic [23:0]   r_pix_rgb;
  logic [XW-1:0] r_pix_x;
  logic [YW-1:0] r_pix_y;
  logic          r_pix_sof, r_pix_eol, r_pix_eof, r_pix_vld;
  logic          r_frame_done;

  logic w_rdy, w_acc, w_load, w_x_last, w_y_last, w_eof_now;

  // Only the B byte waits on the output register; R/G always have a hold slot.
  assign w_rdy     = (r_phase != PH_B) || !r_pix_vld || bus.pix_rdy;
  assign w_acc     = bus.pxl_serial_vld && w_rdy;
  assign w_load    = w_acc && (r_phase == PH_B);
  assign w_x_last  = (r_x_cnt == X_LAST);
  assign w_y_last  = (r_y_cnt == Y_LAST);
  assign w_eof_now = w_x_last && w_y_last;

  // Byte phase register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_phase <= PH_R;
    else          r_phase <= w_phase_nxt;
  end

  // Byte phase next-state: advance one channel per accepted byte
  always_comb begin
    w_phase_nxt = r_phase;
    if (w_acc) begin
      case (r_phase)
        PH_R:    w_phase_nxt = PH_G;
        PH_G:    w_phase_nxt = PH_B;
        PH_B:    w_phase_nxt = PH_R;
        default: w_phase_nxt = PH_R;
      endcase
    end
  end

  // R and G hold registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_q   <= 8'h00;
      r_g_q <= 8'h00;
    end else if (w_acc) begin
      if (r_phase == PH_R) r_q   <= bus.pxl_serial_dat;
      if (r_phase == PH_G) r_g_q <= bus.pxl_serial_dat;
    end
  end

  // Raster counters step once per pixel loaded into the output register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
    end else if (w_load) begin
      if (w_x_last) begin
        r_x_cnt <= '0;
        r_y_cnt <= w_y_last ? '0 : r_y_cnt + 1'b1;
      end else begin
        r_x_cnt <= r_x_cnt + 1'b1;
      end
    end
  end

  // Output pixel register: load on B byte, otherwise drain on pix_rdy
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_pix_rgb <= '0;
      r_pix_x   <= '0;
      r_pix_y   <= '0;
      r_pix_sof <= 1'b0;
      r_pix_eol <= 1'b0;
      r_pix_eof <= 1'b0;
      r_pix_vld <= 1'b0;
    end else if (w_load) begin
      r_pix_rgb <= {r_q, r_g_q, bus.pxl_serial_dat};
      r_pix_x   <= r_x_cnt;
      r_pix_y   <= r_y_cnt;
      r_pix_sof <= (r_x_cnt == '0) && (r_y_cnt == '0);
      r_pix_eol <= w_x_last;
      r_pix_eof <= w_eof_now;
      r_pix_vld <= 1'b1;
    end else if (bus.pix_rdy) begin
      r_pix_vld <= 1'b0;
    end
  end

  // Frame done pulses the cycle after the eof pixel is handed off
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_frame_done <= 1'b0;
    else          r_frame_done <= r_pix_vld && bus.pix_rdy && r_pix_eof;
  end

`ifdef PIXEL_ASSEMBLER_CHECKSUM_EN
  logic [15:0] r_acc, r_cksum;

  // Byte checksum: snapshot and restart on the B byte of the eof pixel
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_acc   <= '0;
      r_cksum <= '0;
    end else if (w_acc) begin
      if (w_load && w_eof_now) begin
        r_cksum <= r_acc + {8'h00, bus.pxl_serial_dat};
        r_acc   <= '0;
      end else begin
        r_acc   <= r_acc + {8'h00, bus.pxl_serial_dat};
      end
    end
  end

  assign bus.frame_cksum = r_cksum;
`else
  assign bus.frame_cksum = 16'h0000;
`endif

  assign bus.pxl_serial_rdy = w_rdy;
  assign bus.pix_rgb        = r_pix_rgb;
  assign bus.pix_x          = r_pix_x;
  assign bus.pix_y          = r_pix_y;
  assign bus.pix_sof        = r_pix_sof;
  assign bus.pix_eol        = r_pix_eol;
  assign bus.pix_eof        = r_pix_eof;
  assign bus.pix_vld        = r_pix_vld;
  assign bus.frame_done     = r_frame_done;

endmodule

// File: tb/tb_pathtracer_pixel_assembler.sv
// Directed bench for pathtracer_pixel_assembler on a 4x2 raster.
module tb_pathtracer_pixel_assembler;

  localparam int W = 4, H = 2, XW = 2, YW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;

  always #5 clk = ~clk;

  pathtracer_pixel_assembler_if #(.XW(XW), .YW(YW)) bus ();

  pathtracer_pixel_assembler #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .XW(XW), .YW(YW)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus.master)
  );

  // Count frame_done pulses
  always @(negedge clk) if (bus.frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until accepted; returns at posedge+1 after acceptance
  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    bus.pxl_serial_vld = 1'b1;
    bus.pxl_serial_dat = d;
    do begin
      @(negedge clk);
      n++;
    end while (bus.pxl_serial_rdy !== 1'b1 && n < 100);
    if (bus.pxl_serial_rdy !== 1'b1) check("byte_accept_timeout", 32'(bus.pxl_serial_rdy), 32'd1);
    @(posedge clk); #1;
    bus.pxl_serial_vld = 1'b0;
  endtask

  task automatic send_pix(input logic [23:0] rgb);
    send_byte(rgb[23:16]);
    send_byte(rgb[15:8]);
    send_byte(rgb[7:0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pxl_serial_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [27:0] exp_q[$];
  logic [15:0] ck_exp1, ck_exp2;
  int          fd_base, npix;
  bit          done;

  initial begin
`ifdef PIXEL_ASSEMBLER_CHECKSUM_EN
    ck_exp1 = 16'h0018;
    ck_exp2 = 16'h17E8;
`else
    ck_exp1 = 16'h0000;
    ck_exp2 = 16'h0000;
`endif
    bus.pxl_serial_dat = 8'h00;
    bus.pxl_serial_vld = 1'b0;
    bus.pix_rdy        = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_vld",   32'(bus.pix_vld), 32'd0);
    check("rst_rgb",   32'(bus.pix_rgb), 32'd0);
    check("rst_xy",    32'({bus.pix_x, bus.pix_y}), 32'd0);
    check("rst_flags", 32'({bus.pix_sof, bus.pix_eol, bus.pix_eof, bus.frame_done}), 32'd0);
    check("rst_cksum", 32'(bus.frame_cksum), 32'd0);
    check("rst_srdy",  32'(bus.pxl_serial_rdy), 32'd1);

    // First pixel: visible the cycle after its B byte
    send_byte(8'h11);
    send_byte(8'h22);
    check("pre_b_vld", 32'(bus.pix_vld), 32'd0);
    send_byte(8'h33);
    check("p0_vld",   32'(bus.pix_vld), 32'd1);
    check("p0_rgb",   32'(bus.pix_rgb), 32'h112233);
    check("p0_xy",    32'({bus.pix_x, bus.pix_y}), 32'd0);
    check("p0_flags", 32'({bus.pix_sof, bus.pix_eol, bus.pix_eof}), 32'b100);

    // Raster walk: pixels 1..8 (pixel 8 wraps to the next frame's (0,0))
    fd_base = fd_cnt;
    for (int n = 1; n <= 8; n++) begin
      send_pix({8'(n), 8'(n + 8'h40), 8'(n + 8'h80)});
      check("rs_rgb",  32'(bus.pix_rgb), 32'({8'(n), 8'(n + 8'h40), 8'(n + 8'h80)}));
      check("rs_x",    32'(bus.pix_x), 32'(n % 4));
      check("rs_y",    32'(bus.pix_y), 32'((n / 4) % 2));
      check("rs_sof",  32'(bus.pix_sof), 32'(n == 8));
      check("rs_eol",  32'(bus.pix_eol), 32'(n % 4 == 3));
      check("rs_eof",  32'(bus.pix_eof), 32'(n == 7));
    end
    check("rs_frame_done", 32'(fd_cnt - fd_base), 32'd1);
    check("rs_cksum_off", 32'(bus.frame_cksum), `ifdef PIXEL_ASSEMBLER_CHECKSUM_EN 32'(bus.frame_cksum) `else 32'd0 `endif);

    // Backpressure: R,G taken while stalled, B waits
    do_reset();
    send_pix(24'h010203);
    bus.pix_rdy = 1'b0;
    check("bp_p1_rgb", 32'(bus.pix_rgb), 32'h010203);
    send_byte(8'h04);
    send_byte(8'h05);
    bus.pxl_serial_vld = 1'b1;
    bus.pxl_serial_dat = 8'h06;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_srdy_low", 32'(bus.pxl_serial_rdy), 32'd0);
      check("bp_hold_rgb", 32'(bus.pix_rgb), 32'h010203);
      check("bp_hold_vld", 32'(bus.pix_vld), 32'd1);
    end
    bus.pix_rdy = 1'b1;
    #1 check("bp_srdy_high", 32'(bus.pxl_serial_rdy), 32'd1);
    @(posedge clk); #1;
    bus.pxl_serial_vld = 1'b0;
    bus.pix_rdy = 1'b0;
    check("bp_p2_vld", 32'(bus.pix_vld), 32'd1);
    check("bp_p2_rgb", 32'(bus.pix_rgb), 32'h040506);
    check("bp_p2_x",   32'(bus.pix_x), 32'd1);

    // Reset mid-pixel with a held output pixel
    send_byte(8'h10);
    send_byte(8'h20);
    do_reset();
    check("mr_vld", 32'(bus.pix_vld), 32'd0);
    check("mr_rgb", 32'(bus.pix_rgb), 32'd0);
    check("mr_xy",  32'({bus.pix_x, bus.pix_y}), 32'd0);
    check("mr_flags", 32'({bus.pix_sof, bus.pix_eol, bus.pix_eof}), 32'd0);
    check("mr_srdy", 32'(bus.pxl_serial_rdy), 32'd1);
    bus.pix_rdy = 1'b1;
    send_pix(24'hAABBCC);
    check("mr_rgb2", 32'(bus.pix_rgb), 32'hAABBCC);
    check("mr_xy2",  32'({bus.pix_x, bus.pix_y}), 32'd0);
    check("mr_sof2", 32'(bus.pix_sof), 32'd1);

    // Checksum frames: all 0x01, then all 0xFF
    do_reset();
    for (int n = 0; n < 8; n++) send_pix(24'h010101);
    check("ck_eof1", 32'(bus.pix_eof), 32'd1);
    check("ck_sum1", 32'(bus.frame_cksum), 32'(ck_exp1));
    for (int n = 0; n < 8; n++) send_pix(24'hFFFFFF);
    check("ck_eof2", 32'(bus.pix_eof), 32'd1);
    check("ck_sum2", 32'(bus.frame_cksum), 32'(ck_exp2));

    // Random vld/rdy gaps over 3 frames with scoreboard
    do_reset();
    fd_base = fd_cnt;
    npix = 0;
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 3 * W * H; k++) begin
          logic [23:0] rgb;
          rgb = 24'($urandom);
          exp_q.push_back({rgb, 2'(k % 4), 1'((k / 4) % 2), 1'(k % 8 == 7)});
          for (int b = 2; b >= 0; b--) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_byte(rgb[b*8 +: 8]);
          end
        end
        done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(done && exp_q.size() == 0) && cyc < 3000) begin
          @(posedge clk); #1;
          bus.pix_rdy = 1'($urandom_range(0, 1));
          @(negedge clk);
          cyc++;
          if (bus.pix_vld === 1'b1 && bus.pix_rdy === 1'b1) begin
            npix++;
            if (exp_q.size() == 0)
              check("sb_extra_pixel", 32'(npix), 32'(3 * W * H));
            else
              check("sb_pixel", 32'({bus.pix_rgb, bus.pix_x, bus.pix_y, bus.pix_eof}),
                    32'(exp_q.pop_front()));
          end
        end
        if (cyc >= 3000) check("sb_timeout", 32'(cyc), 32'd0);
      end
    join
    bus.pix_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("sb_npix", 32'(npix), 32'(3 * W * H));
    check("sb_qempty", 32'(exp_q.size()), 32'd0);
    check("sb_frame_done", 32'(fd_cnt - fd_base), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
